// File: rtl/j1_uart.sv
// j1_uart -- memory-mapped UART for the J1 I/O bus.
//
// Registers (relative to BASE):
//   +0 DATA   write: queue a byte for transmit; read: {rx_valid, 7'b0, rx_byte}, clears rx_valid
//   +2 STATUS {10'b0, rx_ferr, tx_drop, rx_overrun, rx_valid, tx_empty, tx_full}; read clears bits 3..5
//   +4 DIV    clocks per bit, 16 bits; values below 2 are stored as 2
//
// Ports:
//   sys_clk_i, sys_rst_n_i   clock, synchronous active-low reset
//   io_rd, io_wr, io_addr    J1 bus strobes and address
//   io_dout / io_din         J1 write data in / read data out (combinational, 0 when not hit)
//   hit                      io_addr selects one of this block's registers
//   uart_txd / uart_rxd      serial out (registered, idle high) / serial in (asynchronous)
module j1_uart #(
   parameter logic [15:0] BASE      = 16'h6400,
   parameter logic [15:0] DIV_RESET = 16'd69,
   parameter int unsigned FIFO_LOG2 = 4
) (
   input  logic        sys_clk_i,
   input  logic        sys_rst_n_i,
   input  logic        io_rd,
   input  logic        io_wr,
   input  logic [15:0] io_addr,
   input  logic [15:0] io_dout,
   output logic [15:0] io_din,
   output logic        hit,
   output logic        uart_txd,
   input  logic        uart_rxd
);
   localparam int unsigned DEPTH = 1 << FIFO_LOG2;
   localparam logic [FIFO_LOG2:0]   CNT_FULL = (FIFO_LOG2+1)'(DEPTH);
   localparam logic [FIFO_LOG2:0]   CNT_ONE  = (FIFO_LOG2+1)'(1);
   localparam logic [FIFO_LOG2-1:0] PTR_ONE  = FIFO_LOG2'(1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // ---------------- bus decode ----------------
   logic sel_data, sel_stat, sel_div;
   logic wr_data, rd_data, rd_stat, wr_div;
   assign sel_data = (io_addr == BASE);
   assign sel_stat = (io_addr == BASE + 16'd2);
   assign sel_div  = (io_addr == BASE + 16'd4);
   assign hit      = sel_data | sel_stat | sel_div;
   assign wr_data  = io_wr & sel_data;
   assign rd_data  = io_rd & sel_data;
   assign rd_stat  = io_rd & sel_stat;
   assign wr_div   = io_wr & sel_div;

   // ---------------- registers ----------------
   logic [15:0] div_q;
   logic        rx_valid_q, overrun_q, drop_q, ferr_q;
   logic [7:0]  rx_byte_q;

   // ---------------- TX FIFO ----------------
   logic [7:0]           fifo_mem [DEPTH];
   logic [FIFO_LOG2-1:0] wr_ptr_q, rd_ptr_q;
   logic [FIFO_LOG2:0]   count_q;
   logic                 fifo_full, fifo_empty, push, tx_pop;
   assign fifo_full  = (count_q == CNT_FULL);
   assign fifo_empty = (count_q == '0);
   assign push       = wr_data & ~fifo_full;   // a push into a full FIFO is lost

   always_ff @(posedge sys_clk_i) begin
      if (push) fifo_mem[wr_ptr_q] <= io_dout[7:0];
   end

   always_ff @(posedge sys_clk_i) begin
      if (!sys_rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push)   wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (tx_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
         if (push && !tx_pop)      count_q <= count_q + CNT_ONE;
         else if (!push && tx_pop) count_q <= count_q - CNT_ONE;
      end
   end

   // ---------------- TX FSM ----------------
   tx_state_t   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_shift_q, tx_shift_d;
   logic        txd_q, txd_d, tx_bit_end;
   assign tx_bit_end = (tx_cnt_q == tx_div_q - 16'd1);
   assign uart_txd   = txd_q;

   always_ff @(posedge sys_clk_i) begin
      if (!sys_rst_n_i) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_div_q   <= DIV_RESET;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         txd_q      <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_div_q   <= tx_div_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         txd_q      <= txd_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 16'd1;
      tx_div_d   = tx_div_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      txd_d      = txd_q;
      tx_pop     = 1'b0;
      // Frame start: shared by IDLE and the end of STOP so back-to-back bytes have no gap.
      // The divisor is captured here so a DIV write never stretches a frame in flight.
      if ((tx_state_q == TX_IDLE || (tx_state_q == TX_STOP && tx_bit_end)) && !fifo_empty) begin
         tx_pop     = 1'b1;
         tx_state_d = TX_START;
         tx_cnt_d   = '0;
         tx_div_d   = div_q;
         tx_shift_d = fifo_mem[rd_ptr_q];
         txd_d      = 1'b0;
      end else begin
         case (tx_state_q)
            TX_IDLE: tx_cnt_d = '0;
            TX_START: if (tx_bit_end) begin
               tx_state_d = TX_DATA;
               tx_cnt_d   = '0;
               tx_bit_d   = '0;
               txd_d      = tx_shift_q[0];
               tx_shift_d = tx_shift_q >> 1;
            end
            TX_DATA: if (tx_bit_end) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
                  txd_d      = 1'b1;
               end else begin
                  tx_bit_d   = tx_bit_q + 3'd1;
                  txd_d      = tx_shift_q[0];
                  tx_shift_d = tx_shift_q >> 1;
               end
            end
            TX_STOP: if (tx_bit_end) begin
               tx_state_d = TX_IDLE;
               tx_cnt_d   = '0;
            end
            default: tx_state_d = TX_IDLE;
         endcase
      end
   end

   // ---------------- RX path ----------------
   logic        sync1_q, sync2_q, rx_prev_q;
   rx_state_t   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_done, rx_stop_ok;

   always_ff @(posedge sys_clk_i) begin
      if (!sys_rst_n_i) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_div_q   <= DIV_RESET;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
      end else begin
         sync1_q    <= uart_rxd;
         sync2_q    <= sync1_q;
         rx_prev_q  <= sync2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_div_q   <= rx_div_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 16'd1;
      rx_div_d   = rx_div_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_done    = 1'b0;
      rx_stop_ok = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !sync2_q) begin
               rx_state_d = RX_START;
               rx_div_d   = div_q;
            end
         end
         // Recheck at mid start bit; a line that is high again was a glitch.
         RX_START: if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
            rx_cnt_d   = '0;
            rx_bit_d   = '0;
            rx_state_d = sync2_q ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (rx_cnt_q == rx_div_q - 16'd1) begin
            rx_cnt_d   = '0;
            rx_shift_d = {sync2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            else                  rx_bit_d   = rx_bit_q + 3'd1;
         end
         RX_STOP: if (rx_cnt_q == rx_div_q - 16'd1) begin
            rx_done    = 1'b1;
            rx_stop_ok = sync2_q;
            rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------- register updates ----------------
   always_ff @(posedge sys_clk_i) begin
      if (!sys_rst_n_i) begin
         div_q      <= DIV_RESET;
         rx_valid_q <= 1'b0;
         rx_byte_q  <= '0;
         overrun_q  <= 1'b0;
         drop_q     <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         if (wr_div) div_q <= (io_dout < 16'd2) ? 16'd2 : io_dout;
         // A completing byte loads if the holding register is free or is being read now.
         if (rx_done && rx_stop_ok && (!rx_valid_q || rd_data)) begin
            rx_byte_q  <= rx_shift_q;
            rx_valid_q <= 1'b1;
         end else if (rd_data) begin
            rx_valid_q <= 1'b0;
         end
         // Clear-on-read first so a same-cycle set takes priority.
         if (rd_stat) begin
            overrun_q <= 1'b0;
            drop_q    <= 1'b0;
            ferr_q    <= 1'b0;
         end
         if (rx_done && rx_stop_ok && rx_valid_q && !rd_data) overrun_q <= 1'b1;
         if (wr_data && fifo_full)                            drop_q    <= 1'b1;
         if (rx_done && !rx_stop_ok)                          ferr_q    <= 1'b1;
      end
   end

   // ---------------- read mux ----------------
   logic tx_empty;
   assign tx_empty = fifo_empty & (tx_state_q == TX_IDLE);

   always_comb begin
      io_din = 16'h0000;
      if (sel_data)      io_din = {rx_valid_q, 7'b0, rx_byte_q};
      else if (sel_stat) io_din = {10'b0, ferr_q, drop_q, overrun_q, rx_valid_q, tx_empty, fifo_full};
      else if (sel_div)  io_din = div_q;
   end
endmodule

// File: tb/tb_j1_uart.sv
// Bench for j1_uart: a queue-based model of the FIFO, the transmit line and the
// register file is compared against the DUT every cycle; directed reads also carry
// hand-computed literal expectations.
module tb_j1_uart;
   localparam logic [15:0] A_DATA = 16'h6400;
   localparam logic [15:0] A_STAT = 16'h6402;
   localparam logic [15:0] A_DIV  = 16'h6404;
   localparam int          DEPTH  = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        io_rd, io_wr, uart_rxd;
   logic [15:0] io_addr, io_dout;
   logic [15:0] io_din;
   logic        hit, uart_txd;

   always #5 clk = ~clk;

   j1_uart #(.BASE(16'h6400), .DIV_RESET(16'd4), .FIFO_LOG2(4)) dut (
      .sys_clk_i(clk), .sys_rst_n_i(rst_n),
      .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr), .io_dout(io_dout),
      .io_din(io_din), .hit(hit), .uart_txd(uart_txd), .uart_rxd(uart_rxd)
   );

   int vectors = 0;
   int miscompares = 0;

   // literal expectations posted by the stimulus
   logic        lit_din_en, lit_txd_en, lit_txd;
   logic [15:0] lit_din;
   string       lit_name;

   // RX frame completion events posted by the stimulus
   int          rx_evt_cnt;
   logic [7:0]  rx_evt_byte;
   logic        rx_evt_stop;

   // ---------------- model ----------------
   logic        model_ok = 1'b0;
   logic [7:0]  m_fifo[$];
   int          m_rem, m_cur_div, m_evt_seen;
   logic [7:0]  m_cur_byte;
   logic [15:0] m_div;
   logic        m_rxv, m_ovr, m_drop, m_ferr;
   logic [7:0]  m_rxb;

   initial forever begin
      @(posedge clk);
      if (!rst_n) begin
         m_fifo.delete();
         m_rem = 0; m_cur_div = 4; m_cur_byte = 8'h00; m_div = 16'd4;
         m_rxv = 1'b0; m_rxb = 8'h00; m_ovr = 1'b0; m_drop = 1'b0; m_ferr = 1'b0;
         m_evt_seen = rx_evt_cnt;
         model_ok = 1'b1;
      end else if (model_ok) begin
         logic full_before;
         full_before = (m_fifo.size() == DEPTH);
         // a new frame starts when the line is idle or the last stop cycle ends
         if (m_rem <= 1 && m_fifo.size() > 0) begin
            m_cur_byte = m_fifo.pop_front();
            m_cur_div  = int'(m_div);
            m_rem      = 10 * m_cur_div;
         end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
         end
         if (io_rd && io_addr == A_DATA) m_rxv = 1'b0;
         if (io_rd && io_addr == A_STAT) begin m_ovr = 1'b0; m_drop = 1'b0; m_ferr = 1'b0; end
         if (io_wr && io_addr == A_DATA) begin
            if (full_before) m_drop = 1'b1;
            else             m_fifo.push_back(io_dout[7:0]);
         end
         if (io_wr && io_addr == A_DIV) m_div = (io_dout < 16'd2) ? 16'd2 : io_dout;
         if (rx_evt_cnt != m_evt_seen) begin
            m_evt_seen = rx_evt_cnt;
            if (!rx_evt_stop)  m_ferr = 1'b1;
            else if (m_rxv)    m_ovr  = 1'b1;
            else begin m_rxb = rx_evt_byte; m_rxv = 1'b1; end
         end
      end
   end

   function automatic logic exp_txd();
      int p, b;
      if (m_rem == 0) return 1'b1;
      p = 10 * m_cur_div - m_rem;
      b = p / m_cur_div;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return m_cur_byte[b-1];
   endfunction

   function automatic logic [15:0] exp_din();
      if (io_addr == A_DATA) return {m_rxv, 7'b0, m_rxb};
      if (io_addr == A_STAT) return {10'b0, m_ferr, m_drop, m_ovr, m_rxv,
                                     (m_fifo.size() == 0 && m_rem == 0), (m_fifo.size() == DEPTH)};
      if (io_addr == A_DIV)  return m_div;
      return 16'h0000;
   endfunction

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- compare ----------------
   initial forever begin
      @(negedge clk);
      if (model_ok) begin
         check("txd_model", {15'b0, uart_txd}, {15'b0, exp_txd()});
         check("hit_model", {15'b0, hit},
               {15'b0, (io_addr == A_DATA || io_addr == A_STAT || io_addr == A_DIV)});
         check("din_model", io_din, exp_din());
         if (lit_din_en) check(lit_name, io_din, lit_din);
         if (lit_txd_en) check(lit_name, {15'b0, uart_txd}, {15'b0, lit_txd});
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
      io_wr = 1'b1; io_addr = a; io_dout = d;
      tick();
      io_wr = 1'b0; io_addr = 16'h0000; io_dout = 16'h0000;
   endtask

   task automatic bus_rd(input logic [15:0] a, input string nm, input logic [15:0] exp);
      io_rd = 1'b1; io_addr = a;
      lit_din_en = 1'b1; lit_din = exp; lit_name = nm;
      tick();
      io_rd = 1'b0; io_addr = 16'h0000; lit_din_en = 1'b0;
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop, input int d);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rxd = fr[i];
         repeat (d) tick();
      end
      uart_rxd = 1'b1;
      repeat (3 * d) tick();
      rx_evt_byte = b; rx_evt_stop = stop; rx_evt_cnt = rx_evt_cnt + 1;
      repeat (2) tick();
   endtask

   initial begin
      logic [9:0] a5_bits;
      io_rd = 1'b0; io_wr = 1'b0; io_addr = 16'h0000; io_dout = 16'h0000; uart_rxd = 1'b1;
      lit_din_en = 1'b0; lit_txd_en = 1'b0; lit_txd = 1'b1; lit_din = 16'h0000; lit_name = "";
      rx_evt_cnt = 0; rx_evt_byte = 8'h00; rx_evt_stop = 1'b1;
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      tick();
      bus_rd(A_STAT, "reset_status", 16'h0002);
      bus_rd(A_DIV,  "reset_div",    16'd4);
      bus_rd(A_DATA, "reset_data",   16'h0000);

      // single byte 0xA5: start, LSB-first data, stop, each 4 cycles
      bus_wr(A_DATA, 16'h00A5);
      tick();
      a5_bits = 10'b1_1010_0101_0;
      for (int i = 0; i < 40; i++) begin
         lit_txd_en = 1'b1; lit_txd = a5_bits[i/4]; lit_name = "a5_txd";
         tick();
      end
      lit_txd_en = 1'b0;
      bus_rd(A_STAT, "a5_done_status", 16'h0002);

      // overfill: 1 in flight + 16 queued, the 18th write is dropped
      for (int i = 0; i < 18; i++) bus_wr(A_DATA, 16'(i));
      bus_rd(A_STAT, "full_drop_status", 16'h0011);
      bus_rd(A_STAT, "drop_cleared",     16'h0001);
      repeat (17 * 40 + 10) tick();
      bus_rd(A_STAT, "drained_status",   16'h0002);

      // receive
      rx_frame(8'h3C, 1'b1, 4);
      bus_rd(A_STAT, "rx_status",     16'h0006);
      bus_rd(A_DATA, "rx_data",       16'h803C);
      bus_rd(A_STAT, "rx_status_clr", 16'h0002);
      rx_frame(8'h11, 1'b1, 4);
      rx_frame(8'h22, 1'b1, 4);
      bus_rd(A_DATA, "ovr_data",   16'h8011);
      bus_rd(A_STAT, "ovr_status", 16'h000A);
      bus_rd(A_STAT, "ovr_clr",    16'h0002);
      rx_frame(8'h55, 1'b0, 4);
      bus_rd(A_STAT, "ferr_status", 16'h0022);
      bus_rd(A_STAT, "ferr_clr",    16'h0002);
      uart_rxd = 1'b0; tick(); uart_rxd = 1'b1;
      repeat (20) tick();
      bus_rd(A_STAT, "glitch_status", 16'h0002);
      bus_rd(A_DATA, "glitch_data",   16'h0011);

      // divisor clamp, unmapped addresses, divisor change between frames
      bus_wr(A_DIV, 16'd1);
      bus_rd(A_DIV, "div_min", 16'd2);
      bus_wr(16'h6406, 16'h1234);
      bus_wr(16'h6401, 16'h00FF);
      bus_rd(16'h6406, "unmapped_read", 16'h0000);
      bus_wr(A_DATA, 16'h005A);
      bus_wr(A_DIV,  16'd5);
      bus_wr(A_DATA, 16'h00C3);
      repeat (80) tick();
      rx_frame(8'h96, 1'b1, 5);
      bus_rd(A_DATA, "rx_div5", 16'h8096);

      // reset in the middle of a frame
      bus_wr(A_DATA, 16'h000F);
      bus_wr(A_DATA, 16'h00F0);
      repeat (12) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; lit_txd_en = 1'b1; lit_txd = 1'b1; lit_name = "reset_txd";
      tick();
      lit_txd_en = 1'b0;
      bus_rd(A_STAT, "reset2_status", 16'h0002);
      bus_rd(A_DIV,  "reset2_div",    16'd4);
      repeat (5) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
